dot_seq: RTL and testbench
==========================

DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 Parameter IP, default 8, input operand MSB index; operands are IP+1 bits signed.
REQ-002 Parameter WP, default 8, weight MSB index; weights are WP+1 bits signed.
REQ-003 Parameter LW, default 8, vector-length field width; max length 2^LW-1.
REQ-004 Parameter AW, default IP+WP+2+LW, accumulator/bias/result width in bits, signed.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start_valid  in  1  job request.
REQ-008 start_ready  out  1  job can be accepted.
REQ-009 start_len  in  LW  number of operand pairs in job.
REQ-010 start_bias  in  AW  signed initial accumulator value.
REQ-011 op_valid  in  1  operand pair present.
REQ-012 op_ready  out  1  operand pair accepted this cycle when op_valid also high.
REQ-013 op_in  in  IP+1  signed input operand.
REQ-014 op_w  in  WP+1  signed weight.
REQ-015 res_valid  out  1  result presented.
REQ-016 res_ready  in  1  consumer accepts result.
REQ-017 res_data  out  AW  signed dot-product result.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 States SHALL be IDLE, ACC, DONE; one-hot or binary encoding is implementer's choice.
REQ-020 IDLE: start_ready=1, op_ready=0, res_valid=0; start_valid&start_ready loads acc<=start_bias, cnt<=start_len.
REQ-021 Accepted start with start_len=0 SHALL go IDLE->DONE, res_data=start_bias.
REQ-022 Accepted start with start_len>0 SHALL go IDLE->ACC.
REQ-023 ACC: op_ready=1, start_ready=0; each op_valid&op_ready cycle SHALL set acc<=acc+op_w*op_in and cnt<=cnt-1.
REQ-024 Acceptance of the pair at cnt=1 SHALL go ACC->DONE; res_valid asserts the next cycle (latency 1 cycle after last pair).
REQ-025 Throughput SHALL be one operand pair per cycle; op_valid low stalls ACC with acc and cnt held.
REQ-026 DONE: res_valid=1, res_data=acc, both stable until res_valid&res_ready; then DONE->IDLE.
REQ-027 start_valid outside IDLE SHALL be ignored (start_ready=0); no back-to-back DONE->ACC bypass.
REQ-028 Product SHALL be full-precision signed (IP+WP+2 bits), sign-extended to AW before addition.
REQ-029 Addition SHALL be AW-bit two's-complement, wrapping; AW default guarantees no overflow for any legal job.
REQ-030 op_ready and start_ready SHALL be registered-state decodes only, with no combinational path from any *_valid.

Reset
REQ-031 rst SHALL force state=IDLE, acc=0, cnt=0, res_valid=0, op_ready=0, busy=0, start_ready=1, res_data=0.
REQ-032 rst asserted mid-job SHALL abort it immediately; no partial result is ever presented.

Structure
REQ-033 Shared package SHALL hold the state enum and default IP/WP/LW constants.
REQ-034 Multiply-add SHALL be one instance of the team mac sub-module, with BP=CP=AW-1, acc on b, op_w on w, op_in on in.

Verification
REQ-035 Bias 10, len 3, pairs (2,3),(-4,5),(7,-1) streamed back-to-back -> res_data=-11, res_valid 1 cycle after third accept.
REQ-036 len 0, bias -5 -> DONE next cycle, res_data=-5, op_ready never high.
REQ-037 len 255, all pairs (-256,-256), bias 0 -> res_data=16711680, no overflow.
REQ-038 len 4 with op_valid toggled every other cycle and res_ready held low 5 cycles -> res_data correct, held stable, single result.
REQ-039 rst pulsed after 2 of 4 pairs, then new job len 1 (3,3), bias 1 -> res_data=10 only.
REQ-040 start_valid held high during ACC/DONE -> no second job until IDLE, then exactly one accepted.

Source files
------------

// File: rtl/dot_seq_pkg.sv
// Shared definitions for the dot_seq block: default operand widths and FSM state codes.
package dot_seq_pkg;

    localparam int unsigned IP_DEF = 8;
    localparam int unsigned WP_DEF = 8;
    localparam int unsigned LW_DEF = 8;

    localparam int unsigned ST_W = 2;
    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ACC  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Accumulator width that can hold any legal job without overflow.
    function automatic int unsigned acc_width(input int unsigned ip, input int unsigned wp,
                                              input int unsigned lw);
        return ip + wp + 2 + lw;
    endfunction

endpackage

// File: rtl/dot_seq_mac.sv
// Combinational multiply-add: c = b + sign_extend(w * in), full-precision signed product.
module dot_seq_mac
    import dot_seq_pkg::*;
#(
    parameter int unsigned IP = IP_DEF,
    parameter int unsigned WP = WP_DEF,
    parameter int unsigned BP = acc_width(IP_DEF, WP_DEF, LW_DEF) - 1,
    parameter int unsigned CP = acc_width(IP_DEF, WP_DEF, LW_DEF) - 1
) (
    input  logic [IP:0] in,
    input  logic [WP:0] w,
    input  logic [BP:0] b,
    output logic [CP:0] c_c
);

    localparam int unsigned PW = IP + WP + 2;
    localparam int unsigned CW = CP + 1;

    logic signed [PW-1:0] prod_c;

    // Both factors are sign-extended to the product width so no bits are lost.
    always_comb begin
        prod_c = PW'($signed(w)) * PW'($signed(in));
        c_c    = CW'($signed(b)) + CW'(prod_c);
    end

endmodule

// File: rtl/dot_seq.sv
// Sequential signed dot product: bias plus a stream of operand/weight pairs, one pair per cycle.
module dot_seq
    import dot_seq_pkg::*;
#(
    parameter int unsigned IP = IP_DEF,
    parameter int unsigned WP = WP_DEF,
    parameter int unsigned LW = LW_DEF,
    parameter int unsigned AW = IP + WP + 2 + LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [LW-1:0] start_len,
    input  logic [AW-1:0] start_bias,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [IP:0]   op_in,
    input  logic [WP:0]   op_w,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_data,
    output logic          busy
);

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] mac_sum_c;

    logic start_ready_q, start_ready_d;
    logic op_ready_q, op_ready_d;
    logic res_valid_q, res_valid_d;
    logic busy_q, busy_d;

    dot_seq_mac #(
        .IP (IP),
        .WP (WP),
        .BP (AW - 1),
        .CP (AW - 1)
    ) u_mac (
        .in  (op_in),
        .w   (op_w),
        .b   (acc_q),
        .c_c (mac_sum_c)
    );

    // Next state and datapath; handshake flags are decoded from the next state so they
    // leave flops and never see a *_valid input combinationally.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    acc_d   = start_bias;
                    cnt_d   = start_len;
                    state_d = (start_len == LW'(0)) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (op_valid) begin
                    acc_d = mac_sum_c;
                    cnt_d = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_ready_d = (state_d == ST_IDLE);
        op_ready_d    = (state_d == ST_ACC);
        res_valid_d   = (state_d == ST_DONE);
        busy_d        = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            start_ready_q <= 1'b1;
            op_ready_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            start_ready_q <= start_ready_d;
            op_ready_q    <= op_ready_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign start_ready = start_ready_q;
    assign op_ready    = op_ready_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign res_data    = acc_q;

endmodule

// File: tb/tb_dot_seq.sv
// Self-checking bench for dot_seq: vector table plus hand-written corner sequences, scoreboard on results.
module tb_dot_seq;

    localparam int unsigned IP = 8;
    localparam int unsigned WP = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned AW = IP + WP + 2 + LW;
    localparam int unsigned IW = IP + 1;
    localparam int unsigned WW = WP + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [LW-1:0] start_len;
    logic [AW-1:0] start_bias;
    logic          op_valid;
    logic          op_ready;
    logic [IP:0]   op_in;
    logic [WP:0]   op_w;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_data;
    logic          busy;

    always #5 clk = ~clk;

    dot_seq #(.IP(IP), .WP(WP), .LW(LW), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_len   (start_len),
        .start_bias  (start_bias),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_in       (op_in),
        .op_w        (op_w),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy)
    );

    int            total = 0;
    int            passed = 0;
    longint        sb[$];
    int            starts_seen = 0;
    logic          hold_q = 1'b0;
    logic [AW-1:0] hold_data = '0;
    int            pa[256];
    int            pw[256];

    typedef struct packed {
        logic [7:0]          len;
        logic signed [31:0]  bias;
        logic [3:0][15:0]    a;
        logic [3:0][15:0]    w;
        logic                gap;
        logic [3:0]          rdly;
        logic signed [31:0]  exp;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input int len, input int bias,
                                input int a0, input int w0, input int a1, input int w1,
                                input int a2, input int w2, input int a3, input int w3,
                                input int gap, input int rdly, input int exp);
        vec_t v;
        v.len  = 8'(len);
        v.bias = 32'(bias);
        v.a[0] = 16'(a0); v.w[0] = 16'(w0);
        v.a[1] = 16'(a1); v.w[1] = 16'(w1);
        v.a[2] = 16'(a2); v.w[2] = 16'(w2);
        v.a[3] = 16'(a3); v.w[3] = 16'(w3);
        v.gap  = 1'(gap);
        v.rdly = 4'(rdly);
        v.exp  = 32'(exp);
        return v;
    endfunction

    // Result monitor: scoreboard pop on handshake, hold-stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                check("res_hold_valid", longint'(res_valid), 1);
                check("res_hold_data", longint'($signed(res_data)), longint'($signed(hold_data)));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_result: got %0d, expected no result", $signed(res_data));
                end else begin
                    check("res_data", longint'($signed(res_data)), sb.pop_front());
                end
            end
            hold_q    = res_valid && !res_ready;
            hold_data = res_data;
            if (start_valid && start_ready) starts_seen++;
        end
    end

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic do_start(input int len, input longint bias, input longint exp, input bit keep);
        bit got = 1'b0;
        int cyc = 0;
        start_len   = LW'(len);
        start_bias  = AW'(bias);
        start_valid = 1'b1;
        while (!got && cyc < 50) begin
            @(negedge clk);
            got = start_ready;
            @(posedge clk); #1;
            cyc++;
        end
        if (!keep) start_valid = 1'b0;
        if (!got) begin
            total++;
            $display("FAIL start_timeout: got no start_ready, expected accept within 50 cycles");
        end else begin
            sb.push_back(exp);
        end
        @(negedge clk);
        if (len == 0) begin
            check("len0_res_valid_next", longint'(res_valid), 1);
            check("len0_op_ready", longint'(op_ready), 0);
        end else begin
            check("acc_op_ready", longint'(op_ready), 1);
            check("acc_start_ready", longint'(start_ready), 0);
            check("acc_res_valid", longint'(res_valid), 0);
        end
        check("job_busy", longint'(busy), 1);
        @(posedge clk); #1;
    endtask

    task automatic feed(input int n, input bit gap, input bit chk_last);
        int  i = 0;
        int  cyc = 0;
        bit  tog = 1'b1;
        bit  acc;
        while (i < n && cyc < 2000) begin
            op_valid = gap ? tog : 1'b1;
            op_in    = IW'(pa[i]);
            op_w     = WW'(pw[i]);
            @(negedge clk);
            acc = op_valid && op_ready;
            @(posedge clk); #1;
            if (acc) i++;
            tog = ~tog;
            cyc++;
        end
        op_valid = 1'b0;
        if (i < n) begin
            total++;
            $display("FAIL feed_timeout: got %0d pairs accepted, expected %0d", i, n);
        end
        if (chk_last) begin
            @(negedge clk);
            check("res_latency", longint'(res_valid), 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input int rdly, input bit chk_idle);
        bit got = 1'b0;
        int cyc = 0;
        res_ready = 1'b0;
        repeat (rdly) begin
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        while (!got && cyc < 100) begin
            @(negedge clk);
            got = res_valid;
            @(posedge clk); #1;
            cyc++;
        end
        res_ready = 1'b0;
        if (!got) begin
            total++;
            $display("FAIL result_timeout: got no res_valid, expected result within 100 cycles");
        end
        if (chk_idle) begin
            @(negedge clk);
            check("idle_res_valid", longint'(res_valid), 0);
            check("idle_busy", longint'(busy), 0);
            check("idle_start_ready", longint'(start_ready), 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        vec_t   vecs[6];
        longint sum;
        int     len;
        int     s0;

        vecs[0] = mk(3, 10,    2, 3,   -4, 5,    7, -1,  0, 0,  0, 0, -11);
        vecs[1] = mk(0, -5,    0, 0,    0, 0,    0, 0,   0, 0,  0, 0, -5);
        vecs[2] = mk(4, 0,     1, 1,    2, 2,    3, 3,   4, 4,  1, 5, 30);
        vecs[3] = mk(2, 0,  -256, 255, 255, -256, 0, 0,  0, 0,  0, 1, -130560);
        vecs[4] = mk(1, -100, 255, 255, 0, 0,    0, 0,   0, 0,  1, 2, 64925);
        vecs[5] = mk(1, -1000, -256, -256, 0, 0, 0, 0,   0, 0,  0, 0, 64536);

        rst = 1'b1; start_valid = 1'b0; start_len = '0; start_bias = '0;
        op_valid = 1'b0; op_in = '0; op_w = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_start_ready", longint'(start_ready), 1);
        check("rst_op_ready", longint'(op_ready), 0);
        check("rst_res_valid", longint'(res_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_res_data", longint'($signed(res_data)), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < 4; k++) begin
                pa[k] = int'($signed(vecs[v].a[k]));
                pw[k] = int'($signed(vecs[v].w[k]));
            end
            do_start(int'(vecs[v].len), longint'(vecs[v].bias), longint'(vecs[v].exp), 1'b0);
            if (vecs[v].len != 8'd0) feed(int'(vecs[v].len), vecs[v].gap, 1'b1);
            drain(int'(vecs[v].rdly), 1'b1);
        end

        // Longest job at the most negative corner.
        for (int k = 0; k < 255; k++) begin
            pa[k] = -256;
            pw[k] = -256;
        end
        do_start(255, 0, 16711680, 1'b0);
        feed(255, 1'b0, 1'b1);
        drain(0, 1'b1);

        // Random jobs against a reference sum.
        for (int j = 0; j < 4; j++) begin
            len = int'($urandom_range(1, 12));
            sum = longint'($urandom_range(0, 2000)) - 1000;
            do_start(len, sum, 0, 1'b0);
            void'(sb.pop_back());
            for (int k = 0; k < len; k++) begin
                pa[k] = int'($urandom_range(0, 511)) - 256;
                pw[k] = int'($urandom_range(0, 511)) - 256;
                sum += longint'(pa[k]) * longint'(pw[k]);
            end
            sb.push_back(sum);
            feed(len, 1'($urandom_range(0, 1)), 1'b1);
            drain(int'($urandom_range(0, 3)), 1'b1);
        end

        // Abort mid-job with reset, then a fresh job.
        for (int k = 0; k < 4; k++) begin
            pa[k] = 5;
            pw[k] = 7;
        end
        do_start(4, 0, 0, 1'b0);
        sb.delete();
        feed(2, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_res_valid", longint'(res_valid), 0);
        check("abort_op_ready", longint'(op_ready), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_start_ready", longint'(start_ready), 1);
        check("abort_res_data", longint'($signed(res_data)), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        pa[0] = 3; pw[0] = 3;
        do_start(1, 1, 10, 1'b0);
        feed(1, 1'b0, 1'b1);
        drain(0, 1'b1);

        // start_valid held through ACC and DONE: exactly one further job once back in IDLE.
        s0 = starts_seen;
        pa[0] = 1; pw[0] = 1; pa[1] = 1; pw[1] = 1;
        do_start(2, 0, 2, 1'b1);
        feed(2, 1'b0, 1'b1);
        drain(3, 1'b0);
        check("held_start_once", longint'(starts_seen - s0), 1);
        pa[0] = 2; pw[0] = 2; pa[1] = 2; pw[1] = 2;
        do_start(2, 0, 8, 1'b0);
        feed(2, 1'b0, 1'b1);
        drain(0, 1'b1);
        check("held_start_total", longint'(starts_seen - s0), 2);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", longint'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
